// File: rtl/hybrid_stream_decrypt.sv
// -----------------------------------------------------------------------------
// hybrid_stream_decrypt
//
// Streaming Polybius + Vigenere decryptor. Accepts one Polybius ciphertext
// symbol per cycle over a valid/ready stream and emits one plaintext byte per
// cycle. The repeating Vigenere key (1..KEY_MAX characters) is loaded at run
// time through the cfg_/key_ interface.
//
// Alphabet: index 0..25 = 'A'..'Z', index 26..35 = '0'..'9'.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_start, cfg_key_len          begin a key load of cfg_key_len bytes
//   cfg_err                         one-cycle pulse: cfg_start rejected
//   key_valid, key_data             key bytes, consumed in LOAD only
//   key_err                         sticky: an illegal key byte was loaded
//   s_valid/s_ready/s_data/s_last   ciphertext stream, {row_ascii, col_ascii}
//   m_valid/m_ready/m_data/m_err/m_last  plaintext stream
//   busy                            LOAD in progress or pipeline not empty
//
// Pipeline: stage 1 = Polybius decode + key RAM read, stage 2 = Vigenere
// subtraction, whose register drives the m_* outputs.
// -----------------------------------------------------------------------------
module hybrid_stream_decrypt #(
    parameter int KEY_MAX = 32,
    parameter int KW      = $clog2(KEY_MAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic [KW:0]   cfg_key_len,
    output logic          cfg_err,
    input  logic          key_valid,
    input  logic [7:0]    key_data,
    output logic          key_err,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [15:0]   s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [7:0]    m_data,
    output logic          m_err,
    output logic          m_last,
    output logic          busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [KW:0]   key_len_q, key_len_d;
    logic [KW-1:0] load_cnt_q, load_cnt_d;
    logic [KW-1:0] key_idx_q, key_idx_d;
    logic          key_err_q, key_err_d;
    logic          cfg_err_q, cfg_err_d;
    logic          busy_q, busy_d;

    // Stage 1 registers
    logic          v1_q, v1_d;
    logic [5:0]    c1_q, c1_d;
    logic          e1_q, e1_d;
    logic          l1_q, l1_d;

    // Stage 2 / output registers
    logic          m_valid_q, m_valid_d;
    logic [7:0]    m_data_q, m_data_d;
    logic          m_err_q, m_err_d;
    logic          m_last_q, m_last_d;

    // Key RAM holds alphabet indices, not ASCII, so stage 2 needs no remap.
    logic [5:0]    key_mem [KEY_MAX];
    logic [5:0]    key_rd_q;
    logic          key_we;
    logic [5:0]    key_wd;

    logic          adv1, adv2, accept, pipe_empty, len_ok;
    logic          key_byte_ok;
    logic [5:0]    key_byte_idx;
    logic          row_ok, col_ok;
    logic [2:0]    row_off, col_off;
    logic [5:0]    poly_idx;
    logic [5:0]    vig_idx;
    logic [7:0]    vig_ascii;

    // Handshake
    assign adv2       = !m_valid_q || m_ready;
    assign adv1       = !v1_q || adv2;
    assign s_ready    = (state_q == ST_RUN) && adv1;
    assign accept     = s_valid && s_ready;
    assign pipe_empty = !v1_q && !m_valid_q;
    assign len_ok     = (cfg_key_len != '0) && (cfg_key_len <= (KW+1)'(KEY_MAX));

    // Key byte to alphabet index; illegal bytes store index 0.
    always_comb begin
        key_byte_ok  = 1'b0;
        key_byte_idx = 6'd0;
        if (key_data >= 8'h41 && key_data <= 8'h5A) begin
            key_byte_ok  = 1'b1;
            key_byte_idx = 6'(key_data - 8'h41);
        end else if (key_data >= 8'h30 && key_data <= 8'h39) begin
            key_byte_ok  = 1'b1;
            key_byte_idx = 6'(key_data - 8'h30) + 6'd26;
        end
    end

    // Polybius decode: ASCII '1'..'6' has low bits 1..6, so the offset is
    // the low three bits minus one once the full byte is range-checked.
    always_comb begin
        row_ok   = (s_data[15:8] >= 8'h31) && (s_data[15:8] <= 8'h36);
        col_ok   = (s_data[7:0]  >= 8'h31) && (s_data[7:0]  <= 8'h36);
        row_off  = s_data[10:8] - 3'd1;
        col_off  = s_data[2:0]  - 3'd1;
        poly_idx = ({3'b000, row_off} * 6'd6) + {3'b000, col_off};
    end

    // Vigenere: true result is always 0..35, so 6-bit modular arithmetic in
    // the c+36-k branch yields the exact value despite intermediate overflow.
    always_comb begin
        if (c1_q >= key_rd_q) begin
            vig_idx = c1_q - key_rd_q;
        end else begin
            vig_idx = c1_q + 6'd36 - key_rd_q;
        end
        if (vig_idx < 6'd26) begin
            vig_ascii = {2'b00, vig_idx} + 8'h41;
        end else begin
            vig_ascii = {2'b00, vig_idx - 6'd26} + 8'h30;
        end
    end

    // Control FSM next state
    always_comb begin
        state_d    = state_q;
        key_len_d  = key_len_q;
        load_cnt_d = load_cnt_q;
        key_idx_d  = key_idx_q;
        key_err_d  = key_err_q;
        cfg_err_d  = 1'b0;
        key_we     = 1'b0;
        key_wd     = key_byte_idx;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (len_ok) begin
                        state_d    = ST_LOAD;
                        key_len_d  = cfg_key_len;
                        load_cnt_d = '0;
                        key_err_d  = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (key_valid) begin
                    key_we = 1'b1;
                    if (!key_byte_ok) begin
                        key_err_d = 1'b1;
                    end
                    if ((KW+1)'(load_cnt_q) + (KW+1)'(1) == key_len_q) begin
                        state_d   = ST_RUN;
                        key_idx_d = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    // s_last restarts the key so every message begins at key[0].
                    if (s_last || ((KW+1)'(key_idx_q) == key_len_q - (KW+1)'(1))) begin
                        key_idx_d = '0;
                    end else begin
                        key_idx_d = key_idx_q + 1'b1;
                    end
                end
                if (cfg_start) begin
                    if (len_ok && pipe_empty) begin
                        state_d    = ST_LOAD;
                        key_len_d  = cfg_key_len;
                        load_cnt_d = '0;
                        key_err_d  = 1'b0;
                        key_idx_d  = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next state
    always_comb begin
        v1_d      = v1_q;
        c1_d      = c1_q;
        e1_d      = e1_q;
        l1_d      = l1_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_err_d   = m_err_q;
        m_last_d  = m_last_q;

        if (adv1) begin
            v1_d = accept;
            if (accept) begin
                c1_d = poly_idx;
                e1_d = !(row_ok && col_ok);
                l1_d = s_last;
            end
        end

        if (adv2) begin
            m_valid_d = v1_q;
            if (v1_q) begin
                m_data_d = e1_q ? 8'h3F : vig_ascii;
                m_err_d  = e1_q;
                m_last_d = l1_q;
            end
        end

        busy_d = (state_d == ST_LOAD) || v1_d || m_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_len_q  <= '0;
            load_cnt_q <= '0;
            key_idx_q  <= '0;
            key_err_q  <= 1'b0;
            cfg_err_q  <= 1'b0;
            busy_q     <= 1'b0;
            v1_q       <= 1'b0;
            c1_q       <= '0;
            e1_q       <= 1'b0;
            l1_q       <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'h00;
            m_err_q    <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_len_q  <= key_len_d;
            load_cnt_q <= load_cnt_d;
            key_idx_q  <= key_idx_d;
            key_err_q  <= key_err_d;
            cfg_err_q  <= cfg_err_d;
            busy_q     <= busy_d;
            v1_q       <= v1_d;
            c1_q       <= c1_d;
            e1_q       <= e1_d;
            l1_q       <= l1_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_err_q    <= m_err_d;
            m_last_q   <= m_last_d;
        end
    end

    // Key RAM: synchronous write during LOAD, registered read alongside the
    // stage 1 capture. Contents are not reset.
    always_ff @(posedge clk) begin
        if (key_we) begin
            key_mem[load_cnt_q] <= key_wd;
        end
        if (accept) begin
            key_rd_q <= key_mem[key_idx_q];
        end
    end

    assign cfg_err = cfg_err_q;
    assign key_err = key_err_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_err   = m_err_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_hybrid_stream_decrypt.sv
// -----------------------------------------------------------------------------
// tb_hybrid_stream_decrypt
//
// Directed bench for hybrid_stream_decrypt. A negedge collector records every
// m_valid && m_ready transfer; tests compare those records against
// hand-computed plaintext. One line is printed per received transaction.
// -----------------------------------------------------------------------------
module tb_hybrid_stream_decrypt;

    localparam int KEY_MAX = 32;
    localparam int KW      = $clog2(KEY_MAX);

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic [KW:0]   cfg_key_len;
    logic          cfg_err;
    logic          key_valid;
    logic [7:0]    key_data;
    logic          key_err;
    logic          s_valid;
    logic          s_ready;
    logic [15:0]   s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [7:0]    m_data;
    logic          m_err;
    logic          m_last;
    logic          busy;

    hybrid_stream_decrypt #(.KEY_MAX(KEY_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_key_len (cfg_key_len),
        .cfg_err     (cfg_err),
        .key_valid   (key_valid),
        .key_data    (key_data),
        .key_err     (key_err),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_err       (m_err),
        .m_last      (m_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int first_acc;

    logic [7:0] rx_data [$];
    bit         rx_err  [$];
    bit         rx_last [$];
    int         rx_cyc  [$];

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            rx_data.push_back(m_data);
            rx_err.push_back(m_err);
            rx_last.push_back(m_last);
            rx_cyc.push_back(cyc);
            $display("rx[%0d] cyc=%0d data=%02h err=%0b last=%0b",
                     rx_data.size() - 1, cyc, m_data, m_err, m_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_data.delete();
        rx_err.delete();
        rx_last.delete();
        rx_cyc.delete();
        first_acc = -1;
    endtask

    task automatic cfg_pulse(input int len);
        cfg_start   = 1'b1;
        cfg_key_len = (KW+1)'(len);
        tick();
        cfg_start   = 1'b0;
    endtask

    task automatic load_key(input int len, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] kb [3];
        kb[0] = b0; kb[1] = b1; kb[2] = b2;
        cfg_pulse(len);
        for (int i = 0; i < len; i++) begin
            key_valid = 1'b1;
            key_data  = kb[i];
            tick();
        end
        key_valid = 1'b0;
    endtask

    // Leaves s_valid high so consecutive calls stream back to back.
    task automatic send(input logic [15:0] d, input logic last);
        bit fire;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        fire    = 1'b0;
        for (int n = 0; n < 50 && !fire; n++) begin
            @(negedge clk);
            fire = s_ready;
            if (fire && first_acc < 0) first_acc = cyc;
            tick();
        end
        if (!fire) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 200 && rx_data.size() < n; i++) tick();
        chk("rx_count", rx_data.size(), n);
    endtask

    task automatic check_rx(input string tag, input int i, input logic [7:0] d,
                            input logic e, input logic l);
        if (i < rx_data.size()) begin
            chk({tag, "_data"}, rx_data[i], d);
            chk({tag, "_err"},  rx_err[i],  e);
            chk({tag, "_last"}, rx_last[i], l);
        end else begin
            chk({tag, "_missing"}, rx_data.size(), i + 1);
        end
    endtask

    // Backpressure test expectation: key KEY over R,M,X,K,R,M,X,K
    logic [7:0] bp_exp [8];

    initial begin
        rst = 1'b1; cfg_start = 1'b0; cfg_key_len = '0;
        key_valid = 1'b0; key_data = 8'h00;
        s_valid = 1'b0; s_data = 16'h0000; s_last = 1'b0; m_ready = 1'b1;
        clear_rx();
        bp_exp[0] = "H"; bp_exp[1] = "I"; bp_exp[2] = "9"; bp_exp[3] = "A";
        bp_exp[4] = "N"; bp_exp[5] = "Y"; bp_exp[6] = "N"; bp_exp[7] = "G";
        repeat (3) tick();

        // Reset state
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data",  m_data, 8'h00);
        chk("rst_busy",    busy, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_key_err", key_err, 0);
        rst = 1'b0;
        tick();

        // Config errors in IDLE
        cfg_pulse(0);
        chk("len0_cfg_err", cfg_err, 1);
        chk("len0_idle",    busy, 0);
        tick();
        chk("len0_pulse",   cfg_err, 0);
        cfg_pulse(KEY_MAX + 1);
        chk("lenmax_cfg_err", cfg_err, 1);
        chk("lenmax_idle",    s_ready, 0);
        chk("lenmax_busy",    busy, 0);
        tick();

        // Test 1: key KEY, decode HI9A
        load_key(3, "K", "E", "Y");
        chk("t1_key_err", key_err, 0);
        clear_rx();
        send(16'h3336, 1'b0);
        send(16'h3331, 1'b0);
        send(16'h3436, 1'b0);
        send(16'h3235, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_rx(4);
        check_rx("t1_0", 0, "H", 0, 0);
        check_rx("t1_1", 1, "I", 0, 0);
        check_rx("t1_2", 2, "9", 0, 0);
        check_rx("t1_3", 3, "A", 0, 1);
        if (rx_cyc.size() >= 4) begin
            chk("t1_latency",    rx_cyc[0] - first_acc, 2);
            chk("t1_throughput", rx_cyc[3] - rx_cyc[0], 3);
        end

        // Test 3: invalid symbol, key still advances (K used, then E)
        clear_rx();
        send(16'h3037, 1'b0);
        send(16'h3336, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_rx(2);
        check_rx("t3_inv", 0, 8'h3F, 1, 0);
        check_rx("t3_nxt", 1, "N", 0, 1);

        // Test 6a: message restart resets the key index to 'K'
        clear_rx();
        send(16'h3336, 1'b0);
        send(16'h3331, 1'b1);
        send(16'h3336, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_rx(3);
        check_rx("t6_0", 0, "H", 0, 0);
        check_rx("t6_1", 1, "I", 0, 1);
        check_rx("t6_2", 2, "H", 0, 1);

        // Test 4: backpressure for 5 cycles mid-stream
        clear_rx();
        fork
            begin
                send(16'h3336, 1'b0);
                send(16'h3331, 1'b0);
                send(16'h3436, 1'b0);
                send(16'h3235, 1'b0);
                send(16'h3336, 1'b0);
                send(16'h3331, 1'b0);
                send(16'h3436, 1'b0);
                send(16'h3235, 1'b1);
                s_valid = 1'b0; s_last = 1'b0;
            end
            begin
                tick();
                tick();
                m_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_hold_valid", m_valid, 1);
                    if (rx_data.size() < 8) chk("bp_hold_data", m_data, bp_exp[rx_data.size()]);
                    if (i == 4) chk("bp_s_ready_low", s_ready, 0);
                end
                tick();
                m_ready = 1'b1;
            end
        join
        wait_rx(8);
        for (int i = 0; i < 8; i++) check_rx("bp", i, bp_exp[i], 0, (i == 7));

        // Config error: cfg_start while pipeline holds data stays in RUN
        clear_rx();
        m_ready = 1'b0;
        send(16'h3336, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        tick();
        chk("busy_m_valid", m_valid, 1);
        cfg_pulse(3);
        chk("busy_cfg_err", cfg_err, 1);
        chk("busy_still_run", s_ready, 1);
        m_ready = 1'b1;
        wait_rx(1);
        check_rx("busy_out", 0, "H", 0, 1);
        tick();

        // Test 2: modular wrap with key "K"
        load_key(1, "K", 8'h00, 8'h00);
        clear_rx();
        send(16'h3134, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_rx(1);
        check_rx("t2_wrap", 0, 8'h33, 0, 1);
        tick();

        // Illegal key byte 'a' -> key_err, acts as 'A'
        load_key(1, 8'h61, 8'h00, 8'h00);
        chk("t5_key_err", key_err, 1);
        clear_rx();
        send(16'h3336, 1'b1);
        s_valid = 1'b0; s_last = 1'b0;
        wait_rx(1);
        check_rx("t5_keyA", 0, "R", 0, 1);
        tick();

        // Test 6b: reset during LOAD
        cfg_pulse(3);
        key_valid = 1'b1;
        key_data  = 8'h61;
        tick();
        key_valid = 1'b0;
        chk("t6_load_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_s_ready", s_ready, 0);
        chk("t6_rst_m_valid", m_valid, 0);
        chk("t6_rst_m_data",  m_data, 8'h00);
        chk("t6_rst_m_err",   m_err, 0);
        chk("t6_rst_m_last",  m_last, 0);
        chk("t6_rst_cfg_err", cfg_err, 0);
        chk("t6_rst_key_err", key_err, 0);
        chk("t6_rst_busy",    busy, 0);
        rst = 1'b0;
        tick();
        chk("t6_idle_after", s_ready, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
